// File: rtl/dma_wdata_fifo.sv
// W-channel data FIFO for a DMA engine: first-word-fall-through storage, released as reserved bursts.
// Optional statistics outputs are enabled by defining DMA_WFIFO_STATS_EN.
module dma_wdata_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    i_flush,
    input  logic                    i_rsv_valid,
    input  logic [7:0]              i_rsv_len,
    output logic                    o_rsv_ready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [LW-1:0]           o_level,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_busy,
    output logic [31:0]             o_beat_total,
    output logic [LW-1:0]           o_hwm
);
    localparam int unsigned AW = LW - 1;

    typedef enum logic [1:0] {StIdle, StWaitData, StDrain} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         wptr_q, rptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  full, empty, push, pop;

    state_t                state_q;
    logic [8:0]            beats_q;
    logic [8:0]            remain_q;
    logic                  wvalid_q, wlast_q, rsv_ready_q;

    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);
    assign push  = s_axis_tvalid && !full;
    assign pop   = wvalid_q && i_wready;

    assign s_axis_tready = !full;
    assign o_full        = full;
    assign o_empty       = empty;
    assign o_level       = level_q;
    assign o_wdata       = mem[rptr_q[AW-1:0]];
    assign o_wstrb       = '1;
    assign o_wvalid      = wvalid_q;
    assign o_wlast       = wlast_q;
    assign o_rsv_ready   = rsv_ready_q;
    assign o_busy        = (state_q != StIdle);

    // Storage is deliberately not reset; writes during a flush are discarded by the pointer clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= s_axis_tdata;
        end
    end

    always_comb begin
        level_d = level_q;
        if (i_flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (i_flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + LW'(1);
                if (pop)  rptr_q <= rptr_q + LW'(1);
            end
        end
    end

    // Burst sequencer; wlast is precomputed so it is a registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beats_q     <= '0;
            remain_q    <= '0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            rsv_ready_q <= 1'b1;
        end else if (i_flush) begin
            state_q     <= StIdle;
            remain_q    <= '0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            rsv_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_rsv_valid) begin
                        beats_q     <= {1'b0, i_rsv_len} + 9'd1;
                        state_q     <= StWaitData;
                        rsv_ready_q <= 1'b0;
                    end
                end
                StWaitData: begin
                    if (level_q >= LW'(beats_q)) begin
                        state_q  <= StDrain;
                        remain_q <= beats_q;
                        wvalid_q <= 1'b1;
                        wlast_q  <= (beats_q == 9'd1);
                    end
                end
                StDrain: begin
                    if (pop) begin
                        remain_q <= remain_q - 9'd1;
                        if (wlast_q) begin
                            state_q     <= StIdle;
                            wvalid_q    <= 1'b0;
                            wlast_q     <= 1'b0;
                            rsv_ready_q <= 1'b1;
                        end else begin
                            wlast_q <= (remain_q == 9'd2);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DMA_WFIFO_STATS_EN
    logic [31:0]   beat_total_q;
    logic [LW-1:0] hwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total_q <= '0;
            hwm_q        <= '0;
        end else begin
            if (pop && !i_flush) beat_total_q <= beat_total_q + 32'd1;
            if (i_flush) begin
                hwm_q <= '0;
            end else if (level_d > hwm_q) begin
                hwm_q <= level_d;
            end
        end
    end

    assign o_beat_total = beat_total_q;
    assign o_hwm        = hwm_q;
`else
    assign o_beat_total = '0;
    assign o_hwm        = '0;
`endif

endmodule

// File: tb/tb_dma_wdata_fifo.sv
// Randomized bench for dma_wdata_fifo against a queue-based reference model.
module tb_dma_wdata_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic            clk, rst_n;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid, s_axis_tready;
    logic            i_flush, i_rsv_valid, o_rsv_ready;
    logic [7:0]      i_rsv_len;
    logic [DW-1:0]   o_wdata;
    logic [DW/8-1:0] o_wstrb;
    logic            o_wlast, o_wvalid, i_wready;
    logic [LW-1:0]   o_level, o_hwm;
    logic            o_full, o_empty, o_busy;
    logic [31:0]     o_beat_total;

    dma_wdata_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .i_flush      (i_flush),
        .i_rsv_valid  (i_rsv_valid),
        .i_rsv_len    (i_rsv_len),
        .o_rsv_ready  (o_rsv_ready),
        .o_wdata      (o_wdata),
        .o_wstrb      (o_wstrb),
        .o_wlast      (o_wlast),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_level      (o_level),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_busy       (o_busy),
        .o_beat_total (o_beat_total),
        .o_hwm        (o_hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue holds stored beats; mode 0 idle, 1 waiting for data, 2 draining.
    logic [DW-1:0] mq[$];
    int            mode, need, left, hwm_m;
    int unsigned   beats_m;
    int            n_cmp, n_mis;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mode    = 0;
        need    = 0;
        left    = 0;
        hwm_m   = 0;
        beats_m = 0;
    endtask

    task automatic model_step(input bit tv, input logic [DW-1:0] td, input bit fl,
                              input bit rv, input int len, input bit wr);
        int sz;
        int m;
        sz = mq.size();
        m  = mode;
        if (fl) begin
            mq.delete();
            mode  = 0;
            left  = 0;
            hwm_m = 0;
            return;
        end
        if (m == 2 && wr) begin
            void'(mq.pop_front());
            beats_m++;
            left--;
            if (left == 0) mode = 0;
        end else if (m == 0 && rv) begin
            need = len + 1;
            mode = 1;
        end else if (m == 1 && sz >= need) begin
            mode = 2;
            left = need;
        end
        if (tv && sz < DEPTH) mq.push_back(td);
        if (mq.size() > hwm_m) hwm_m = mq.size();
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        check_eq("level", 32'(o_level), 32'(sz));
        check_eq("empty", 32'(o_empty), 32'(sz == 0));
        check_eq("full", 32'(o_full), 32'(sz == DEPTH));
        check_eq("tready", 32'(s_axis_tready), 32'(sz != DEPTH));
        check_eq("rsv_ready", 32'(o_rsv_ready), 32'(mode == 0));
        check_eq("wvalid", 32'(o_wvalid), 32'(mode == 2));
        check_eq("wlast", 32'(o_wlast), 32'(mode == 2 && left == 1));
        check_eq("busy", 32'(o_busy), 32'(mode != 0));
        check_eq("wstrb", 32'(o_wstrb), 32'hf);
        if (mode == 2) check_eq("wdata", o_wdata, mq[0]);
`ifdef DMA_WFIFO_STATS_EN
        check_eq("beat_total", o_beat_total, beats_m);
        check_eq("hwm", 32'(o_hwm), 32'(hwm_m));
`else
        check_eq("beat_total", o_beat_total, 32'd0);
        check_eq("hwm", 32'(o_hwm), 32'd0);
`endif
    endtask

    // Percent probabilities per cycle for tvalid, reservation, wready, flush.
    task automatic run_cycles(input int n, input int pv, input int pr, input int pw,
                              input int pf, input int maxlen);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = ($urandom_range(99) < pv);
            s_axis_tdata  = $urandom;
            i_rsv_valid   = ($urandom_range(99) < pr);
            i_rsv_len     = 8'($urandom_range(maxlen));
            i_wready      = ($urandom_range(99) < pw);
            i_flush       = ($urandom_range(99) < pf);
            @(posedge clk);
            model_step(s_axis_tvalid, s_axis_tdata, i_flush, i_rsv_valid, int'(i_rsv_len),
                       i_wready);
            #1;
            check_outputs();
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_mis         = 0;
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        i_flush       = 1'b0;
        i_rsv_valid   = 1'b0;
        i_rsv_len     = '0;
        i_wready      = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        run_cycles(200, 60, 10, 70, 0, 31);
        run_cycles(600, 100, 0, 0, 0, 0);    // fill to full, extra beats must be refused
        run_cycles(300, 50, 30, 60, 0, 255); // long bursts with stalls and pointer wrap
        run_cycles(400, 70, 20, 50, 2, 15);  // flushes in all states

        for (int i = 0; i < 500 && mode != 2; i++) run_cycles(1, 80, 50, 30, 0, 63);
        check_eq("reach_drain", 32'(mode), 32'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #3;
        rst_n = 1'b1;

        run_cycles(300, 60, 10, 70, 1, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
